// File: rtl/fetch_pc_unit_if.sv
// Fetch-side bus bundle: instruction-memory req/ack channel and the valid/ready
// channel toward decode. The fetch unit uses the master view.
interface fetch_pc_unit_if;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr_out;
  logic [63:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  modport master (
    output imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    input  imem_ack, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_out, instr_pc, instr_valid,
    output imem_ack, imem_rdata, instr_ready
  );
endinterface

// File: rtl/fetch_pc_unit.sv
// Fetch PC unit: owns the PC, fetches over req/ack, hands words to decode, takes branch redirects.
// Optional misaligned-redirect fault detection is enabled with `define FETCH_ALIGN_CHECK_EN.
module fetch_pc_unit #(
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic                 CLK,
  input  logic                 resetl,
  fetch_pc_unit_if.master      bus,
  input  logic                 redirect_valid,
  input  logic [63:0]          redirect_pc,
  input  logic [63:0]          redirect_imm,
  output logic [63:0]          currentpc
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic                 fetch_fault
`endif
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      r_state, w_state_nxt;
  logic [63:0] r_pc, w_pc_nxt;
  logic        r_kill, w_kill_nxt;
  logic        r_req, w_req_nxt;
  logic [63:0] r_addr, w_addr_nxt;
  logic [31:0] r_instr, w_instr_nxt;
  logic [63:0] r_ipc, w_ipc_nxt;
  logic        r_valid, w_valid_nxt;
  logic        w_issue;
  logic [63:0] w_offset;
  logic [63:0] w_target;
  logic        w_redir_ok;
  logic        w_fault;
  logic        w_fault_nxt;

  assign w_offset = redirect_imm << 2;

`ifdef FETCH_ALIGN_CHECK_EN
  logic r_fault;
  logic w_misalign;

  assign w_misalign  = redirect_valid && (redirect_pc[1:0] != 2'b00);
  assign w_redir_ok  = !w_misalign;
  assign w_target    = redirect_pc + w_offset;
  assign w_fault     = r_fault;
  assign w_fault_nxt = r_fault || w_misalign;
  assign fetch_fault = r_fault;

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) r_fault <= 1'b0;
    else         r_fault <= w_fault_nxt;
  end
`else
  assign w_redir_ok  = 1'b1;
  assign w_target    = (redirect_pc & ~64'h3) + w_offset;
  assign w_fault     = 1'b0;
  assign w_fault_nxt = 1'b0;
`endif

  // Entering S_REQ raises the next request immediately so a zero-wait memory
  // sustains one instruction every two cycles.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_kill_nxt  = r_kill;
    w_req_nxt   = r_req;
    w_addr_nxt  = r_addr;
    w_instr_nxt = r_instr;
    w_ipc_nxt   = r_ipc;
    w_valid_nxt = r_valid;
    w_issue     = 1'b0;

    if (redirect_valid) begin
      w_valid_nxt = 1'b0;
      if (w_redir_ok) w_pc_nxt = w_target;
      if (r_req && !bus.imem_ack) begin
        w_kill_nxt  = 1'b1;
        w_state_nxt = S_WAIT;
      end else begin
        w_kill_nxt = 1'b0;
        w_req_nxt  = 1'b0;
        w_issue    = 1'b1;
      end
    end else begin
      unique case (r_state)
        S_REQ, S_WAIT: begin
          if (r_req && bus.imem_ack) begin
            w_req_nxt = 1'b0;
            if (r_kill || w_fault) begin
              w_kill_nxt = 1'b0;
              w_issue    = 1'b1;
            end else begin
              w_instr_nxt = bus.imem_rdata;
              w_ipc_nxt   = r_addr;
              w_valid_nxt = 1'b1;
              w_pc_nxt    = r_pc + 64'd4;
              w_state_nxt = S_HOLD;
            end
          end else if (r_req) begin
            w_state_nxt = S_WAIT;
          end else if (!w_fault) begin
            w_req_nxt   = 1'b1;
            w_addr_nxt  = r_pc;
            w_state_nxt = S_WAIT;
          end
        end
        S_HOLD: begin
          if (bus.instr_ready) begin
            w_valid_nxt = 1'b0;
            w_issue     = 1'b1;
          end
        end
        default: w_state_nxt = S_REQ;
      endcase
    end

    if (w_issue) begin
      w_state_nxt = S_REQ;
      if (!w_fault_nxt) begin
        w_req_nxt  = 1'b1;
        w_addr_nxt = w_pc_nxt;
      end
    end
  end

  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      r_state <= S_REQ;
      r_pc    <= RESET_PC;
      r_kill  <= 1'b0;
      r_req   <= 1'b0;
      r_addr  <= RESET_PC;
      r_instr <= 32'h0;
      r_ipc   <= 64'h0;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_kill  <= w_kill_nxt;
      r_req   <= w_req_nxt;
      r_addr  <= w_addr_nxt;
      r_instr <= w_instr_nxt;
      r_ipc   <= w_ipc_nxt;
      r_valid <= w_valid_nxt;
    end
  end

  assign bus.imem_req    = r_req;
  assign bus.imem_addr   = r_addr;
  assign bus.instr_out   = r_instr;
  assign bus.instr_pc    = r_ipc;
  assign bus.instr_valid = r_valid;
  assign currentpc       = r_pc;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Directed bench for fetch_pc_unit: memory model with programmable ack latency,
// hand-computed expectations per cycle, sampled on the falling clock edge.
module tb_fetch_pc_unit;

  logic        CLK;
  logic        resetl;
  logic        redirectValid;
  logic [63:0] redirectPc;
  logic [63:0] redirectImm;
  logic [63:0] currentPc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetchFault;
`endif

  int errCount;
  int checkCount;
  int ackDelay;
  int waitCnt;

  fetch_pc_unit_if bus ();

  fetch_pc_unit #(.RESET_PC(64'h0)) dut (
    .CLK            (CLK),
    .resetl         (resetl),
    .bus            (bus),
    .redirect_valid (redirectValid),
    .redirect_pc    (redirectPc),
    .redirect_imm   (redirectImm),
    .currentpc      (currentPc)
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    .fetch_fault    (fetchFault)
`endif
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Memory answers after ackDelay cycles of an outstanding request; data encodes the address.
  always @(posedge CLK or negedge resetl) begin
    if (!resetl)                             waitCnt <= 0;
    else if (bus.imem_req && !bus.imem_ack)  waitCnt <= waitCnt + 1;
    else                                     waitCnt <= 0;
  end

  assign bus.imem_ack   = bus.imem_req && (waitCnt >= ackDelay);
  assign bus.imem_rdata = 32'hC0DE_0000 | {16'h0, bus.imem_addr[15:0]};

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic tick;
    @(negedge CLK);
  endtask

  task automatic applyStimulus(input logic valid, input logic [63:0] pc, input logic [63:0] imm);
    redirectValid = valid;
    redirectPc    = pc;
    redirectImm   = imm;
  endtask

  task automatic doReset(input int delay);
    resetl = 1'b0;
    applyStimulus(1'b0, 64'h0, 64'h0);
    bus.instr_ready = 1'b1;
    ackDelay = delay;
    tick;
    tick;
    resetl = 1'b1;
    tick;
  endtask

  initial begin
    errCount   = 0;
    checkCount = 0;
    resetl = 1'b0;
    applyStimulus(1'b0, 64'h0, 64'h0);
    bus.instr_ready = 1'b1;
    ackDelay = 0;
    tick;
    tick;
    checkOutput("rst_req",   bus.imem_req, 1'b0);
    checkOutput("rst_valid", bus.instr_valid, 1'b0);
    checkOutput("rst_instr", bus.instr_out, 32'h0);
    checkOutput("rst_ipc",   bus.instr_pc, 64'h0);
    checkOutput("rst_pc",    currentPc, 64'h0);
    checkOutput("rst_addr",  bus.imem_addr, 64'h0);
`ifdef FETCH_ALIGN_CHECK_EN
    checkOutput("rst_fault", fetchFault, 1'b0);
`endif
    resetl = 1'b1;

    // Zero-wait streaming: 0x0, 0x4, 0x8, one instruction every two cycles.
    tick;
    checkOutput("s_req0",   bus.imem_req, 1'b1);
    checkOutput("s_addr0",  bus.imem_addr, 64'h0);
    checkOutput("s_val0lo", bus.instr_valid, 1'b0);
    tick;
    checkOutput("s_val0",   bus.instr_valid, 1'b1);
    checkOutput("s_instr0", bus.instr_out, 32'hC0DE_0000);
    checkOutput("s_ipc0",   bus.instr_pc, 64'h0);
    checkOutput("s_pc0",    currentPc, 64'h4);
    checkOutput("s_reqlo",  bus.imem_req, 1'b0);
    tick;
    checkOutput("s_val1lo", bus.instr_valid, 1'b0);
    checkOutput("s_addr1",  bus.imem_addr, 64'h4);
    tick;
    checkOutput("s_val1",   bus.instr_valid, 1'b1);
    checkOutput("s_ipc1",   bus.instr_pc, 64'h4);
    checkOutput("s_instr1", bus.instr_out, 32'hC0DE_0004);
    tick;
    checkOutput("s_val2lo", bus.instr_valid, 1'b0);
    tick;
    checkOutput("s_val2",   bus.instr_valid, 1'b1);
    checkOutput("s_ipc2",   bus.instr_pc, 64'h8);
    checkOutput("s_pc2",    currentPc, 64'hC);

    // Decode stalls four cycles, then memory takes three wait cycles.
    bus.instr_ready = 1'b0;
    ackDelay = 3;
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("stall_valid", bus.instr_valid, 1'b1);
      checkOutput("stall_instr", bus.instr_out, 32'hC0DE_0008);
      checkOutput("stall_req",   bus.imem_req, 1'b0);
    end
    bus.instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      checkOutput("wait_req",   bus.imem_req, 1'b1);
      checkOutput("wait_addr",  bus.imem_addr, 64'hC);
      checkOutput("wait_valid", bus.instr_valid, 1'b0);
      checkOutput("wait_pc",    currentPc, 64'hC);
    end
    tick;
    checkOutput("wait_done_valid", bus.instr_valid, 1'b1);
    checkOutput("wait_done_ipc",   bus.instr_pc, 64'hC);
    checkOutput("wait_done_pc",    currentPc, 64'h10);
    tick;
    checkOutput("wait_once_valid", bus.instr_valid, 1'b0);
    checkOutput("wait_once_pc",    currentPc, 64'h10);

    // Redirect while a request is outstanding: returned word is dropped.
    doReset(5);
    checkOutput("kill_req0", bus.imem_req, 1'b1);
    applyStimulus(1'b1, 64'h100, 64'hFFFF_FFFF_FFFF_FFFE);
    tick;
    applyStimulus(1'b0, 64'h0, 64'h0);
    ackDelay = 0;
    checkOutput("kill_pc",    currentPc, 64'hF8);
    checkOutput("kill_hold",  bus.imem_addr, 64'h0);
    checkOutput("kill_req",   bus.imem_req, 1'b1);
    tick;
    checkOutput("kill_drop",  bus.instr_valid, 1'b0);
    checkOutput("kill_addr",  bus.imem_addr, 64'hF8);
    checkOutput("kill_reqn",  bus.imem_req, 1'b1);
    tick;
    checkOutput("kill_valid", bus.instr_valid, 1'b1);
    checkOutput("kill_ipc",   bus.instr_pc, 64'hF8);
    checkOutput("kill_instr", bus.instr_out, 32'hC0DE_00F8);

    // Redirect coinciding with ack, then redirect in HOLD with ready high.
    doReset(0);
    applyStimulus(1'b1, 64'h200, 64'h4);
    tick;
    applyStimulus(1'b0, 64'h0, 64'h0);
    checkOutput("ackr_valid", bus.instr_valid, 1'b0);
    checkOutput("ackr_addr",  bus.imem_addr, 64'h210);
    checkOutput("ackr_req",   bus.imem_req, 1'b1);
    checkOutput("ackr_pc",    currentPc, 64'h210);
    tick;
    checkOutput("ackr_ipc",   bus.instr_pc, 64'h210);
    checkOutput("ackr_val",   bus.instr_valid, 1'b1);
    applyStimulus(1'b1, 64'h1000, 64'h10);
    tick;
    applyStimulus(1'b0, 64'h0, 64'h0);
    checkOutput("hold_squash", bus.instr_valid, 1'b0);
    checkOutput("hold_addr",   bus.imem_addr, 64'h1040);
    checkOutput("hold_pc",     currentPc, 64'h1040);
    tick;
    checkOutput("hold_ipc",    bus.instr_pc, 64'h1040);
    checkOutput("hold_instr",  bus.instr_out, 32'hC0DE_1040);

    // Target at the top of the address space; pc+4 wraps to zero.
    applyStimulus(1'b1, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF);
    tick;
    applyStimulus(1'b0, 64'h0, 64'h0);
    checkOutput("wrap_addr",  bus.imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    tick;
    checkOutput("wrap_ipc",   bus.instr_pc, 64'hFFFF_FFFF_FFFF_FFFC);
    checkOutput("wrap_instr", bus.instr_out, 32'hC0DE_FFFC);
    checkOutput("wrap_pc",    currentPc, 64'h0);

`ifdef FETCH_ALIGN_CHECK_EN
    begin
      logic sawReq;
      applyStimulus(1'b1, 64'h102, 64'h1);
      tick;
      applyStimulus(1'b0, 64'h0, 64'h0);
      checkOutput("flt_fault", fetchFault, 1'b1);
      checkOutput("flt_valid", bus.instr_valid, 1'b0);
      checkOutput("flt_pc",    currentPc, 64'h0);
      sawReq = 1'b0;
      for (int i = 0; i < 8; i++) begin
        tick;
        if (bus.imem_req || bus.instr_valid) sawReq = 1'b1;
      end
      checkOutput("flt_noreq",  sawReq, 1'b0);
      checkOutput("flt_sticky", fetchFault, 1'b1);
      resetl = 1'b0;
      tick;
      checkOutput("flt_clear",  fetchFault, 1'b0);
      resetl = 1'b1;
      tick;
      checkOutput("flt_resume", bus.imem_req, 1'b1);
    end
`else
    // Low PC bits of the branch are ignored when computing the target.
    applyStimulus(1'b1, 64'h103, 64'h1);
    tick;
    applyStimulus(1'b0, 64'h0, 64'h0);
    checkOutput("mis_addr", bus.imem_addr, 64'h104);
    checkOutput("mis_pc",   currentPc, 64'h104);
    tick;
    checkOutput("mis_ipc",  bus.instr_pc, 64'h104);
`endif

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
